// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the legal operand-width range.
package serial_adder_pkg;

    // State encoding; the unused code 2'd3 is treated as illegal and recovers to IDLE.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_SHIFT   = ST_SHIFT,
        S_DONE    = ST_DONE,
        S_ILLEGAL = 2'd3
    } state_e;

    // Supported operand widths.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder, shared by serial and ripple datapaths.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, LSB first,
// one bit per clock through a single full-adder cell and a carry flop.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed overflow
// output ovf, updated together with sum.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    generate
        if (!width_legal(WIDTH)) begin : g_width_check
            $error("serial_adder: WIDTH out of supported range");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds the WIDTH-1 sum bits produced so far; the final bit joins at the MSB.
    logic [WIDTH-2:0] s_sh_q, s_sh_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_out_q, carry_out_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] s_cat;

    fa_cell u_fa (
        .a_i   (a_sh_q[0]),
        .b_i   (b_sh_q[0]),
        .cin_i (c_q),
        .s_o   (fa_s),
        .cout_o(fa_cout)
    );

    // Newest sum bit enters at the top; after the last bit this is the full result.
    assign s_cat = {fa_s, s_sh_q};

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        s_sh_d      = s_sh_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = carry_in;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                c_d    = fa_cout;
                s_sh_d = s_cat[WIDTH-1:1];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d     = S_DONE;
                    sum_d       = s_cat;
                    carry_out_d = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    // c_q is the carry into the MSB during the last bit.
                    ovf_d       = c_q ^ fa_cout;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            s_sh_q      <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            s_sh_q      <= s_sh_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign busy      = (state_q == S_SHIFT);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for directed and
// random operations, and a 4-bit instance for an exhaustive sweep.
// Define SERIAL_ADDER_OVF_EN to also check the ovf output.
module tb_serial_adder;

    localparam int W  = 8;
    localparam int W4 = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          carry_in = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done, carry_out;
    logic [W-1:0]  sum;

    logic          start4 = 1'b0;
    logic          cin4 = 1'b0;
    logic [W4-1:0] a4 = '0;
    logic [W4-1:0] b4 = '0;
    logic          busy4, done4, carry_out4;
    logic [W4-1:0] sum4;
`ifdef SERIAL_ADDER_OVF_EN
    logic          ovf, ovf4;
`endif

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .carry_in(carry_in),
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_adder #(.WIDTH(W4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .carry_in(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .carry_out(carry_out4)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf4)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] sum;
        logic       co;
        logic       ovf;
        int         done_cyc;
    } exp_t;

    exp_t       q8[$];
    exp_t       q4[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    logic [7:0] held_sum = '0;
    logic       held_co = 1'b0;
    logic       held_ovf = 1'b0;

    // Edge counter: at a falling edge, cyc equals the number of rising edges seen.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer addition over WIDTH bits plus carry.
    function automatic exp_t model(input int width, input logic [7:0] ea, input logic [7:0] eb,
                                   input logic ec, input int st);
        exp_t e;
        int   total;
        int   mask;
        mask  = (1 << width) - 1;
        total = int'(ea) + int'(eb) + int'(ec);
        e.a   = ea;
        e.b   = eb;
        e.c   = ec;
        e.sum = 8'(total & mask);
        e.co  = ((total >> width) & 1) != 0;
        e.ovf = (ea[width-1] == eb[width-1]) && (e.sum[width-1] != ea[width-1]);
        e.done_cyc = st + width;
        return e;
    endfunction

    // 8-bit monitor: checks busy/done every cycle, the result on done, and holding otherwise.
    always @(negedge clk) begin : mon8
        bit   de, be;
        exp_t e;
        if (mon_en) begin
            de = (q8.size() > 0) && (cyc == q8[0].done_cyc);
            be = (q8.size() > 0) && (cyc <  q8[0].done_cyc);
            check("busy", 32'(busy), 32'(be));
            check("done", 32'(done), 32'(de));
            if (de) begin
                e = q8.pop_front();
                $display("op8 a=0x%02h b=0x%02h cin=%0d -> sum=0x%02h co=%0d (expect 0x%02h/%0d)",
                         e.a, e.b, e.c, sum, carry_out, e.sum, e.co);
                check("sum", 32'(sum), 32'(e.sum));
                check("carry_out", 32'(carry_out), 32'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
                held_ovf = e.ovf;
`endif
                held_sum = e.sum;
                held_co  = e.co;
            end else begin
                check("sum_hold", 32'(sum), 32'(held_sum));
                check("carry_hold", 32'(carry_out), 32'(held_co));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf_hold", 32'(ovf), 32'(held_ovf));
`endif
            end
        end
    end

    // 4-bit monitor: result and timing on each done, overdue results flagged.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (mon_en) begin
            if (done4) begin
                if (q4.size() == 0) begin
                    check("done4_unexpected", 32'(done4), 32'd0);
                end else begin
                    e = q4.pop_front();
                    $display("op4 a=0x%0h b=0x%0h cin=%0d -> sum=0x%0h co=%0d", e.a, e.b, e.c, sum4, carry_out4);
                    check("done4_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("sum4", 32'(sum4), 32'(e.sum));
                    check("carry_out4", 32'(carry_out4), 32'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
                    check("ovf4", 32'(ovf4), 32'(e.ovf));
`endif
                end
            end else if (q4.size() > 0 && cyc >= q4[0].done_cyc) begin
                e = q4.pop_front();
                check("done4_missing", 32'(done4), 32'd1);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the last reset edge.
    task automatic do_reset(input int n);
        rst_n  = 1'b0;
        start  = 1'b0;
        start4 = 1'b0;
        repeat (n) @(posedge clk);
        q8.delete();
        q4.delete();
        held_sum = '0;
        held_co  = 1'b0;
        held_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a falling edge; drives a start for one cycle and records the expectation.
    task automatic launch8(input logic [7:0] ea, input logic [7:0] eb, input logic ec, output int st);
        a = ea; b = eb; carry_in = ec; start = 1'b1;
        st = cyc + 1;
        @(posedge clk);
        q8.push_back(model(W, ea, eb, ec, st));
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        carry_in = 1'($urandom);
    endtask

    task automatic run8(input logic [7:0] ea, input logic [7:0] eb, input logic ec);
        int st;
        launch8(ea, eb, ec, st);
        while (cyc < st + W) @(negedge clk);
    endtask

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int st;
        int st2;
        @(negedge clk);
        do_reset(3);
        mon_en = 1'b1;
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_carry", 32'(carry_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        repeat (20) @(negedge clk);

        // Directed corner cases.
        run8(8'h3C, 8'h05, 1'b1);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'h7F, 8'h01, 1'b0);
        run8(8'h00, 8'h00, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1);
        repeat (2) @(negedge clk);

        // Start held high: ignored during SHIFT, accepted in DONE with new operands.
        a = 8'h10; b = 8'h20; carry_in = 1'b0; start = 1'b1;
        st = cyc + 1;
        @(posedge clk);
        q8.push_back(model(W, 8'h10, 8'h20, 1'b0, st));
        repeat (3) @(negedge clk);
        a = 8'h01; b = 8'h02;
        while (cyc < st + W) @(negedge clk);
        st2 = cyc + 1;
        @(posedge clk);
        q8.push_back(model(W, 8'h01, 8'h02, 1'b0, st2));
        @(negedge clk);
        start = 1'b0;
        while (cyc < st2 + W) @(negedge clk);
        repeat (2) @(negedge clk);

        // Reset during the fourth SHIFT cycle: no done, no partial result.
        launch8(8'hAA, 8'h55, 1'b0, st);
        repeat (3) @(negedge clk);
        do_reset(1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_sum", 32'(sum), 32'd0);
        repeat (12) @(negedge clk);

        // Random operations with random gaps, including back-to-back starts.
        for (int i = 0; i < 40; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Exhaustive 4-bit sweep, issued back to back.
        for (int i = 0; i < 512; i++) begin
            a4 = W4'(i); b4 = W4'(i >> 4); cin4 = 1'(i >> 8); start4 = 1'b1;
            st = cyc + 1;
            @(posedge clk);
            q4.push_back(model(W4, 8'(i & 15), 8'((i >> 4) & 15), 1'(i >> 8), st));
            @(negedge clk);
            start4 = 1'b0;
            while (cyc < st + W4) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
